resize_coord_sched: RTL and testbench

RESIZE_COORD_SCHED -- requirements
Module: resize_coord_sched

---
 rtl/resize_coord_sched_if.sv | 35 +++
 rtl/resize_coord_sched.sv | 177 +++++++++++++++++
 tb/tb_resize_coord_sched.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/resize_coord_sched_if.sv
// Resize job-list scheduler bus: configuration/start in, job stream out.
// Master drives the request side, slave is the scheduler.
interface resize_coord_sched_if;
  logic       start;
  logic [6:0] H0;
  logic [6:0] V0;
  logic [4:0] SW;
  logic [4:0] SH;
  logic [5:0] TW;
  logic [5:0] TH;
  logic       job_ready;
  logic       job_valid;
  logic [6:0] src_h;
  logic [6:0] src_v;
  logic [5:0] rem_h;
  logic [5:0] rem_v;
  logic [5:0] tgt_h;
  logic [5:0] tgt_v;
  logic       last;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, H0, V0, SW, SH, TW, TH, job_ready,
    input  job_valid, src_h, src_v, rem_h, rem_v,
    input  tgt_h, tgt_v, last, busy, done, err
  );

  modport slave (
    input  start, H0, V0, SW, SH, TW, TH, job_ready,
    output job_valid, src_h, src_v, rem_h, rem_v,
    output tgt_h, tgt_v, last, busy, done, err
  );
endinterface

// File: rtl/resize_coord_sched.sv
// Resize coordinate scheduler: walks the target grid row-major and
// emits source coordinates from a pair of integer DDAs.
module resize_coord_sched #(
  parameter int IMG_DIM = 100
) (
  input logic                 CLK,
  input logic                 RST,
  resize_coord_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FIN
  } state_t;

  localparam logic [7:0] DIM = 8'(IMG_DIM);

  state_t     state;
  logic [6:0] h0, v0;
  logic [4:0] sw, sh;
  logic [5:0] tw, th;

  logic [6:0] src_h, src_v;
  logic [5:0] rem_h, rem_v;
  logic [5:0] tgt_h, tgt_v;
  logic       job_valid, last;
  logic       busy, done, err;

  logic       bad;
  logic       accept;
  logic [5:0] tw1, th1;
  logic [6:0] sum_h, sum_v;
  logic [6:0] n_src_h, n_src_v;
  logic [5:0] n_rem_h, n_rem_v;
  logic [5:0] n_tgt_h, n_tgt_v;
  logic       n_last;

  assign accept = job_valid & bus.job_ready;

  // Reject windows that are empty, upscale-inverted or leave the ROM.
  always_comb begin
    bad = (tw < 6'd2) || (th < 6'd2) ||
          (sw == 5'd0) || (sh == 5'd0) ||
          ({1'b0, sw} > tw) || ({1'b0, sh} > th) ||
          (({1'b0, h0} + {3'b0, sw}) > DIM) ||
          (({1'b0, v0} + {3'b0, sh}) > DIM);
  end

  // Next job: horizontal DDA step, or row wrap with vertical step.
  always_comb begin
    tw1     = tw - 6'd1;
    th1     = th - 6'd1;
    sum_h   = {1'b0, rem_h} + {2'b0, sw} - 7'd1;
    sum_v   = {1'b0, rem_v} + {2'b0, sh} - 7'd1;
    n_src_h = src_h;
    n_src_v = src_v;
    n_rem_h = rem_h;
    n_rem_v = rem_v;
    n_tgt_h = tgt_h;
    n_tgt_v = tgt_v;
    if (tgt_h != tw1) begin
      n_tgt_h = tgt_h + 6'd1;
      if (sum_h >= {1'b0, tw1}) begin
        n_rem_h = sum_h[5:0] - tw1;
        n_src_h = src_h + 7'd1;
      end else begin
        n_rem_h = sum_h[5:0];
      end
    end else begin
      n_tgt_h = 6'd0;
      n_rem_h = 6'd0;
      n_src_h = h0;
      n_tgt_v = tgt_v + 6'd1;
      if (sum_v >= {1'b0, th1}) begin
        n_rem_v = sum_v[5:0] - th1;
        n_src_v = src_v + 7'd1;
      end else begin
        n_rem_v = sum_v[5:0];
      end
    end
    n_last = (n_tgt_h == tw1) && (n_tgt_v == th1);
  end

  // Control FSM with registered job and status outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      h0        <= '0;
      v0        <= '0;
      sw        <= '0;
      sh        <= '0;
      tw        <= '0;
      th        <= '0;
      src_h     <= '0;
      src_v     <= '0;
      rem_h     <= '0;
      rem_v     <= '0;
      tgt_h     <= '0;
      tgt_v     <= '0;
      job_valid <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            h0    <= bus.H0;
            v0    <= bus.V0;
            sw    <= bus.SW;
            sh    <= bus.SH;
            tw    <= bus.TW;
            th    <= bus.TH;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (bad) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else begin
            src_h     <= h0;
            src_v     <= v0;
            rem_h     <= '0;
            rem_v     <= '0;
            tgt_h     <= '0;
            tgt_v     <= '0;
            last      <= 1'b0;
            job_valid <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (last) begin
              job_valid <= 1'b0;
              last      <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= FIN;
            end else begin
              src_h <= n_src_h;
              src_v <= n_src_v;
              rem_h <= n_rem_h;
              rem_v <= n_rem_v;
              tgt_h <= n_tgt_h;
              tgt_v <= n_tgt_v;
              last  <= n_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.job_valid = job_valid;
  assign bus.src_h     = src_h;
  assign bus.src_v     = src_v;
  assign bus.rem_h     = rem_h;
  assign bus.rem_v     = rem_v;
  assign bus.tgt_h     = tgt_h;
  assign bus.tgt_v     = tgt_v;
  assign bus.last      = last;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;

endmodule

// File: tb/tb_resize_coord_sched.sv
// Bench for resize_coord_sched: table of configurations checked
// against a closed-form coordinate model, plus reset/start corners.
module tb_resize_coord_sched;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  resize_coord_sched_if ifc ();

  resize_coord_sched #(
    .IMG_DIM(100)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(ifc)
  );

  typedef struct {
    logic [6:0] h0;
    logic [6:0] v0;
    logic [4:0] sw;
    logic [4:0] sh;
    logic [5:0] tw;
    logic [5:0] th;
    bit         rnd;
    bit         exp_err;
    int         exp_lh;
    int         exp_lv;
  } vec_t;

  vec_t tbl[9];
  int   n_vec = 0;
  int   n_bad = 0;
  int   nj;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [38:0] job_now();
    return {ifc.src_h, ifc.src_v, ifc.rem_h, ifc.rem_v,
            ifc.tgt_h, ifc.tgt_v, ifc.last};
  endfunction

  // Closed form: source offset of target k is k*(S-1)/(T-1).
  function automatic logic [38:0] model(input vec_t c, input int k);
    int tw, th, sw, sh, th_i, tv_i, nh, nv;
    tw   = int'(c.tw);
    th   = int'(c.th);
    sw   = int'(c.sw);
    sh   = int'(c.sh);
    th_i = k % tw;
    tv_i = k / tw;
    nh   = th_i * (sw - 1);
    nv   = tv_i * (sh - 1);
    return {7'(int'(c.h0) + nh / (tw - 1)),
            7'(int'(c.v0) + nv / (th - 1)),
            6'(nh % (tw - 1)), 6'(nv % (th - 1)),
            6'(th_i), 6'(tv_i),
            1'(k == tw * th - 1)};
  endfunction

  task automatic run(input vec_t c, input int stop_after,
                     input bit poke, output int njobs);
    int         idx;
    int         exp_n;
    bit         stalled;
    bit         fin;
    bit         exp_done;
    logic [38:0] held;
    idx      = 0;
    stalled  = 0;
    fin      = 0;
    exp_done = 0;
    held     = '0;
    exp_n    = c.exp_err ? 0 : int'(c.tw) * int'(c.th);
    @(negedge CLK);
    ifc.H0        = c.h0;
    ifc.V0        = c.v0;
    ifc.SW        = c.sw;
    ifc.SH        = c.sh;
    ifc.TW        = c.tw;
    ifc.TH        = c.th;
    ifc.job_ready = 1'b0;
    ifc.start     = 1'b1;
    @(negedge CLK);
    ifc.start = 1'b0;
    check("load_state", {ifc.busy, ifc.job_valid, ifc.err, ifc.done},
          4'b1000);
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      @(negedge CLK);
      ifc.start = 1'b0;
      if (exp_done) check("done_timing", 64'(ifc.done), 64'd1);
      if (ifc.done) begin
        fin = 1;
      end else if (ifc.job_valid) begin
        if (stalled) check("stall_hold", 64'(job_now()), 64'(held));
        if (poke && idx == 50) begin
          ifc.start = 1'b1;
          ifc.H0    = 7'd0;
          ifc.SW    = 5'd1;
          ifc.TW    = 6'd2;
        end
        ifc.job_ready = c.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ifc.job_ready) begin
          check("job", 64'(job_now()), 64'(model(c, idx)));
          if (ifc.last) begin
            check("last_src", {ifc.src_h, ifc.src_v},
                  {7'(c.exp_lh), 7'(c.exp_lv)});
            exp_done = 1;
          end
          idx++;
          stalled = 0;
          if (idx == stop_after) break;
        end else begin
          held    = job_now();
          stalled = 1;
        end
      end
    end
    njobs = idx;
    if (stop_after == 0) begin
      if (!fin) begin
        n_vec++;
        n_bad++;
        $display("FAIL timeout: got no done, want done");
      end
      check("job_count", 64'(idx), 64'(exp_n));
      check("done_err", {ifc.done, ifc.err}, {1'b1, c.exp_err});
      if (poke) begin
        ifc.start = 1'b1;
        ifc.TW    = 6'd2;
      end
      @(negedge CLK);
      ifc.start     = 1'b0;
      ifc.job_ready = 1'b0;
      check("after_done", {ifc.done, ifc.busy, ifc.job_valid, ifc.err},
            {3'b000, c.exp_err});
      if (poke) begin
        @(negedge CLK);
        check("start_ignored", {ifc.busy, ifc.job_valid}, 2'b00);
      end
    end
  endtask

  initial begin
    tbl[0] = '{7'd81, 7'd18, 5'd17, 5'd15, 6'd22, 6'd28, 0, 0, 97, 32};
    tbl[1] = '{7'd81, 7'd18, 5'd17, 5'd15, 6'd22, 6'd28, 1, 0, 97, 32};
    tbl[2] = '{7'd81, 7'd18, 5'd1,  5'd15, 6'd1,  6'd28, 0, 1, 0, 0};
    tbl[3] = '{7'd10, 7'd10, 5'd20, 5'd4,  6'd10, 6'd8,  0, 1, 0, 0};
    tbl[4] = '{7'd90, 7'd10, 5'd17, 5'd4,  6'd20, 6'd8,  0, 1, 0, 0};
    tbl[5] = '{7'd0,  7'd0,  5'd4,  5'd4,  6'd4,  6'd4,  0, 0, 3, 3};
    tbl[6] = '{7'd5,  7'd6,  5'd1,  5'd1,  6'd2,  6'd2,  1, 0, 5, 6};
    tbl[7] = '{7'd83, 7'd80, 5'd17, 5'd20, 6'd30, 6'd20, 1, 0, 99, 99};
    tbl[8] = '{7'd0,  7'd0,  5'd3,  5'd0,  6'd4,  6'd4,  0, 1, 0, 0};

    ifc.start     = 1'b0;
    ifc.H0        = '0;
    ifc.V0        = '0;
    ifc.SW        = '0;
    ifc.SH        = '0;
    ifc.TW        = '0;
    ifc.TH        = '0;
    ifc.job_ready = 1'b0;

    repeat (3) @(negedge CLK);
    check("reset_state",
          {ifc.job_valid, ifc.busy, ifc.done, ifc.err, job_now()}, '0);
    RST = 1'b1;

    run(tbl[0], 0, 1, nj);
    for (int i = 1; i < 9; i++) run(tbl[i], 0, 0, nj);

    run(tbl[0], 100, 0, nj);
    check("pre_reset_jobs", 64'(nj), 64'd100);
    @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    check("reset_mid_run",
          {ifc.job_valid, ifc.busy, ifc.done, ifc.err, job_now()}, '0);
    @(negedge CLK);
    RST           = 1'b1;
    ifc.job_ready = 1'b1;
    repeat (3) @(negedge CLK);
    check("no_resume", {ifc.busy, ifc.job_valid, ifc.done}, 3'b000);
    run(tbl[0], 0, 0, nj);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
